reorder_buffer: RTL

Parametrised circular reorder buffer that replaces the per-entry ROB slices with a single block holding DEPTH entries and head/tail pointers. It sits between the instruction handler and the register file.

- Allocation: entries are allocated in program order from the instruction handler.
- Writeback: each entry captures its result from the common data bus (CDB) by reservation-station index.
- Commit: results retire strictly in order from the head, one per cycle, driving the register-file write port.

---
 rtl/reorder_buffer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer
// Circular reorder buffer of DEPTH entries, placed between the instruction
// handler and the register file. Entries are allocated in program order at
// the tail. Each entry captures its result from the common data bus by
// reservation-station index. Entries retire in order from the head, at most
// one per cycle, and each retirement drives the register-file write port.
//
// Optional feature: define ROB_FLUSH_EN to add the flush port, which squashes
// every entry.
//
// Ports:
//   clk, rst_n       clock; synchronous active-low reset
//   alloc_valid      allocation request from the instruction handler
//   alloc_ready      allocation accepted this cycle (!full)
//   alloc_instr      instruction logged in the new entry
//   alloc_rs_idx     reservation station that will produce the result
//   alloc_tag        tail index, i.e. the entry receiving this allocation
//   cdb_valid        CDB broadcast valid
//   cdb_rs_idx       producer index on the CDB
//   cdb_value        result on the CDB
//   flush            squash all entries (ROB_FLUSH_EN only)
//   commit_valid     register-file write enable
//   commit_dest      destination register, taken from instr[11:7] of the head
//   commit_value     value to write
//   count            number of occupied entries
//   full, empty      occupancy flags, derived from count
//
// Entry states:
//   state | meaning
//   IDLE  | free slot
//   WAIT  | allocated, result not yet seen on the CDB
//   DONE  | result captured, waiting to retire

module reorder_buffer #(
  parameter int DEPTH    = 8,
  parameter int DATA_W   = 32,
  parameter int RS_IDX_W = 4,
  parameter int TAG_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  input  logic [31:0]         alloc_instr,
  input  logic [RS_IDX_W-1:0] alloc_rs_idx,
  output logic [TAG_W-1:0]    alloc_tag,
  input  logic                cdb_valid,
  input  logic [RS_IDX_W-1:0] cdb_rs_idx,
  input  logic [DATA_W-1:0]   cdb_value,
`ifdef ROB_FLUSH_EN
  input  logic                flush,
`endif
  output logic                commit_valid,
  output logic [4:0]          commit_dest,
  output logic [DATA_W-1:0]   commit_value,
  output logic [TAG_W:0]      count,
  output logic                full,
  output logic                empty
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

  logic [1:0]          st_q    [DEPTH];
  logic [31:0]         instr_q [DEPTH];
  logic [RS_IDX_W-1:0] rs_q    [DEPTH];
  logic [DATA_W-1:0]   val_q   [DEPTH];

  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [TAG_W:0]   cnt_q;

  logic head_done;
  logic head_hit;
  logic commit_ok;
  logic alloc_fire;
  logic unused_instr_bits;

  // Only the destination field of the logged instruction leaves the block.
  assign unused_instr_bits = ^{instr_q[head_q][31:12], instr_q[head_q][6:0]};

  assign count       = cnt_q;
  assign full        = (cnt_q == DEPTH_CNT);
  assign empty       = (cnt_q == '0);
  // alloc_ready depends on registered occupancy only, so a commit in the same
  // cycle cannot open a slot for an allocation.
  assign alloc_ready = !full;
  assign alloc_tag   = tail_q;
  assign alloc_fire  = alloc_valid && alloc_ready;

  assign head_done = (st_q[head_q] == DONE);
  // Same-cycle bypass: the head is still waiting, but its result is on the
  // bus right now.
  assign head_hit  = cdb_valid && (st_q[head_q] == WAIT) &&
                     (rs_q[head_q] == cdb_rs_idx);

`ifdef ROB_FLUSH_EN
  assign commit_ok = (head_done || head_hit) && !flush;
`else
  assign commit_ok = head_done || head_hit;
`endif

  always_comb begin
    commit_valid = commit_ok;
    commit_dest  = '0;
    commit_value = '0;
    if (commit_ok) begin
      commit_dest  = instr_q[head_q][11:7];
      commit_value = head_done ? val_q[head_q] : cdb_value;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]    <= IDLE;
        instr_q[i] <= '0;
        rs_q[i]    <= '0;
        val_q[i]   <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
`ifdef ROB_FLUSH_EN
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          st_q[i]    <= IDLE;
          instr_q[i] <= '0;
          rs_q[i]    <= '0;
          val_q[i]   <= '0;
        end
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
      end else
`endif
      begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cdb_valid && (st_q[i] == WAIT) && (rs_q[i] == cdb_rs_idx)) begin
            val_q[i] <= cdb_value;
            st_q[i]  <= DONE;
          end
        end

        // The head and the tail address the same slot only when the buffer
        // is empty, where nothing commits, or full, where nothing
        // allocates. These writes therefore never collide, and they take
        // priority over the capture above for their own entry.
        if (commit_ok) begin
          st_q[head_q]    <= IDLE;
          instr_q[head_q] <= '0;
          head_q          <= head_q + TAG_W'(1);
        end

        if (alloc_fire) begin
          st_q[tail_q]    <= WAIT;
          instr_q[tail_q] <= alloc_instr;
          rs_q[tail_q]    <= alloc_rs_idx;
          val_q[tail_q]   <= '0;
          tail_q          <= tail_q + TAG_W'(1);
        end

        case ({alloc_fire, commit_ok})
          2'b10:   cnt_q <= cnt_q + (TAG_W+1)'(1);
          2'b01:   cnt_q <= cnt_q - (TAG_W+1)'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

endmodule
